// File: rtl/axi2dcc_mailbox.sv
// AXI4-Lite slave with scratch registers and a bidirectional DCC mailbox.
// The host pushes words into the TX FIFO through TXDATA and pops the RX FIFO
// through RXDATA. The DCC side drains TX and fills RX with valid/ready.
module axi2dcc_mailbox #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_SCRATCH        = 4,
   parameter int FIFO_DEPTH         = 8
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   dcc_tx_data,
   output logic                            dcc_tx_valid,
   input  logic                            dcc_tx_ready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   dcc_rx_data,
   input  logic                            dcc_rx_valid,
   output logic                            dcc_rx_ready,
   output logic                            irq
);

   localparam int DW  = C_S_AXI_DATA_WIDTH;
   localparam int AW  = C_S_AXI_ADDR_WIDTH;
   localparam int LSB = $clog2(DW / 8);
   localparam int IW  = AW - LSB;
   localparam int PW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [IW-1:0] wr_idx, rd_idx;
   logic          wr_hs, ar_hs, wr_any;
   logic          sel_w_ctrl, sel_w_tx, sel_r_status, sel_r_rx;
   logic          ctrl_wr, tx_flush, rx_flush;
   logic [1:0]    irq_en;          // {irq_en_tx_empty, irq_en_rx_nonempty}
   logic          tx_ovf_q, rx_udf_q;
   logic [DW-1:0] scratch [NUM_SCRATCH];

   logic [DW-1:0] tx_mem [FIFO_DEPTH];
   logic [DW-1:0] rx_mem [FIFO_DEPTH];
   logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr, tx_count, rx_count;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          tx_push, tx_pop, tx_ovf, rx_push, rx_pop, rx_udf;

   logic [DW-1:0] rdata_nxt;
   logic [1:0]    rresp_nxt;

   // Handshakes and address decode
   assign wr_hs         = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~ARESET;
   assign S_AXI_AWREADY = wr_hs;
   assign S_AXI_WREADY  = wr_hs;
   assign S_AXI_ARREADY = ~S_AXI_RVALID & ~ARESET;
   assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;
   assign wr_idx        = S_AXI_AWADDR[AW-1:LSB];
   assign rd_idx        = S_AXI_ARADDR[AW-1:LSB];
   assign wr_any        = |S_AXI_WSTRB;
   assign sel_w_ctrl    = (int'(wr_idx) == 0);
   assign sel_w_tx      = (int'(wr_idx) == 2);
   assign sel_r_status  = (int'(rd_idx) == 1);
   assign sel_r_rx      = (int'(rd_idx) == 3);

   // Flush requests are pulses taken straight from the CTRL write
   assign ctrl_wr  = wr_hs & sel_w_ctrl & S_AXI_WSTRB[0];
   assign tx_flush = ctrl_wr & S_AXI_WDATA[0];
   assign rx_flush = ctrl_wr & S_AXI_WDATA[1];

   // FIFO status from extra-bit pointers
   assign tx_count = tx_wr_ptr - tx_rd_ptr;
   assign rx_count = rx_wr_ptr - rx_rd_ptr;
   assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
   assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
   assign tx_full  = (tx_count == PW'(FIFO_DEPTH));
   assign rx_full  = (rx_count == PW'(FIFO_DEPTH));

   assign tx_push = wr_hs & sel_w_tx & wr_any & ~tx_full;
   assign tx_ovf  = wr_hs & sel_w_tx & wr_any & tx_full;
   assign tx_pop  = dcc_tx_valid & dcc_tx_ready;
   assign rx_push = dcc_rx_valid & dcc_rx_ready;
   assign rx_pop  = ar_hs & sel_r_rx & ~rx_empty;
   assign rx_udf  = ar_hs & sel_r_rx & rx_empty;

   assign dcc_tx_valid = ~tx_empty & ~ARESET;
   assign dcc_tx_data  = tx_mem[tx_rd_ptr[PW-2:0]];
   assign dcc_rx_ready = ~rx_full & ~ARESET;

   // TX FIFO pointers; a flush clears both and overrides any push
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ACLK) begin
      if (ARESET || tx_flush) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      end
   end

   // RX FIFO pointers; a flush clears both and overrides any push
   always_ff @(posedge ACLK) begin
      if (ARESET || rx_flush) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      end
   end

   // FIFO storage
   // NOTE: storage arrays are not reset; pointers alone decide which entries are valid.
   always_ff @(posedge ACLK) begin
      if (tx_push) tx_mem[tx_wr_ptr[PW-2:0]] <= S_AXI_WDATA;
      if (rx_push) rx_mem[rx_wr_ptr[PW-2:0]] <= dcc_rx_data;
   end

   // CTRL enables and scratch registers with byte strobes
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         irq_en <= '0;
         for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
      end else if (wr_hs) begin
         if (ctrl_wr) irq_en <= S_AXI_WDATA[3:2];
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (int'(wr_idx) == i + 4) begin
               for (int b = 0; b < DW / 8; b++)
                  if (S_AXI_WSTRB[b]) scratch[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
         end
      end
   end

   // Sticky error flags; cleared by a STATUS read, a same-cycle error wins
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         tx_ovf_q <= 1'b0;
         rx_udf_q <= 1'b0;
      end else begin
         if (ar_hs && sel_r_status) begin
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
         end
         if (tx_ovf) tx_ovf_q <= 1'b1;
         if (rx_udf) rx_udf_q <= 1'b1;
      end
   end

   // Write response channel
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
      end else if (wr_hs) begin
         S_AXI_BVALID <= 1'b1;
         S_AXI_BRESP  <= tx_ovf ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BREADY) begin
         S_AXI_BVALID <= 1'b0;
      end
   end

   // Read data decode for the current AR address
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rdata_nxt = '0;
      rresp_nxt = RESP_OKAY;
      if (int'(rd_idx) == 0) begin
         rdata_nxt[3:2] = irq_en;
      end else if (sel_r_status) begin
         rdata_nxt[5:0]  = {rx_udf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};
         rdata_nxt[15:8] = 8'(rx_count);
      end else if (sel_r_rx) begin
         if (rx_empty) rresp_nxt = RESP_SLVERR;
         else          rdata_nxt = rx_mem[rx_rd_ptr[PW-2:0]];
      end else begin
         for (int i = 0; i < NUM_SCRATCH; i++)
            if (int'(rd_idx) == i + 4) rdata_nxt = scratch[i];
      end
   end

   // Read response channel; data registered in the AR handshake cycle
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rdata_nxt;
         S_AXI_RRESP  <= rresp_nxt;
      end else if (S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

   // Registered level interrupt
   always_ff @(posedge ACLK) begin
      if (ARESET) irq <= 1'b0;
      else        irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
   end

   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

endmodule

// File: tb/tb_axi2dcc_mailbox.sv
// Directed testbench for axi2dcc_mailbox: registers, both FIFOs, flush,
// sticky errors, irq and reset in the middle of a write response.
module tb_axi2dcc_mailbox;

   logic        clk = 1'b0;
   logic        areset;
   logic [5:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [31:0] tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

   int passed = 0;
   int total  = 0;

   localparam logic [5:0] A_CTRL = 6'h00, A_STATUS = 6'h04, A_TX = 6'h08, A_RX = 6'h0C;

   always #5 clk = ~clk;

   axi2dcc_mailbox dut (
      .ACLK(clk), .ARESET(areset),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .dcc_tx_data(tx_data), .dcc_tx_valid(tx_valid), .dcc_tx_ready(tx_ready),
      .dcc_rx_data(rx_data), .dcc_rx_valid(rx_valid), .dcc_rx_ready(rx_ready),
      .irq(irq)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      logic ok;
      resp = 2'b11;
      @(posedge clk); #1;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (awready && wready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      if (!ok) check("aw_handshake_timeout", ok, 1);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bvalid) begin ok = 1'b1; resp = bresp; break; end
      end
      if (!ok) check("b_timeout", ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
      logic ok;
      data = 32'hDEAD_DEAD; resp = 2'b11;
      @(posedge clk); #1;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (arready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      if (!ok) check("ar_timeout", ok, 1);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rvalid) begin ok = 1'b1; data = rdata; resp = rresp; break; end
      end
      if (!ok) check("r_timeout", ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic push_rx(input logic [31:0] data);
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = data;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   logic [31:0] d;
   logic [1:0]  r;

   initial begin
      areset = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_rx_ready", rx_ready, 0);
      check("rst_irq", irq, 0);
      @(posedge clk); #1;
      areset = 1'b0;
      @(negedge clk);
      check("rx_ready_after_rst", rx_ready, 1);

      // Scratch registers and simple decode
      for (int i = 0; i < 4; i++) begin
         axi_write(6'h10 + 6'(4 * i), 32'(i + 1), 4'hF, r);
         check("scratch_wr_resp", r, 2'b00);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(6'h10 + 6'(4 * i), d, r);
         check("scratch_rd", d, 32'(i + 1));
         check("scratch_rd_resp", r, 2'b00);
      end
      axi_write(6'h10, 32'hAABB_CCDD, 4'b0010, r);
      axi_read(6'h10, d, r);
      check("scratch_strobe", d, 32'h0000_CC01);
      axi_read(6'h3C, d, r);
      check("unmapped_rd", d, 0);
      check("unmapped_resp", r, 2'b00);
      axi_read(A_STATUS, d, r);
      check("status_idle", d, 32'h0000_000A);

      // TX fill to overflow
      for (int i = 0; i < 9; i++) begin
         axi_write(A_TX, 32'hA0 + 32'(i), 4'hF, r);
         check("tx_push_resp", r, (i < 8) ? 2'b00 : 2'b10);
      end
      axi_read(A_STATUS, d, r);
      check("status_tx_full_ovf", d, 32'h0000_0019);
      axi_read(A_STATUS, d, r);
      check("status_ovf_cleared", d, 32'h0000_0009);

      // TX drain to DCC
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("tx_drain_valid", tx_valid, 1);
         check("tx_drain_data", tx_data, 32'hA0 + 32'(i));
      end
      @(negedge clk);
      check("tx_drained_valid", tx_valid, 0);
      @(posedge clk); #1;
      tx_ready = 1'b0;

      // RX path, irq and underflow
      axi_write(A_CTRL, 32'h5, 4'hF, r);
      axi_read(A_CTRL, d, r);
      check("ctrl_readback", d, 32'h4);
      @(negedge clk);
      check("irq_rx_empty", irq, 0);
      push_rx(32'h55);
      push_rx(32'h66);
      axi_read(A_STATUS, d, r);
      check("status_rx2", d, 32'h0000_0202);
      @(negedge clk);
      check("irq_rx_nonempty", irq, 1);
      axi_read(A_RX, d, r);
      check("rx_pop0", d, 32'h55);
      check("rx_pop0_resp", r, 2'b00);
      axi_read(A_RX, d, r);
      check("rx_pop1", d, 32'h66);
      axi_read(A_RX, d, r);
      check("rx_underflow_data", d, 0);
      check("rx_underflow_resp", r, 2'b10);
      @(negedge clk);
      check("irq_rx_drained", irq, 0);
      axi_read(A_STATUS, d, r);
      check("status_udf", d, 32'h0000_002A);
      axi_write(A_CTRL, 32'h8, 4'hF, r);
      @(negedge clk);
      check("irq_tx_empty", irq, 1);
      axi_write(A_CTRL, 32'h0, 4'hF, r);
      @(negedge clk);
      check("irq_disabled", irq, 0);

      // RX full boundary, then flush
      for (int i = 0; i < 8; i++) push_rx(32'h100 + 32'(i));
      @(negedge clk);
      check("rx_full_ready", rx_ready, 0);
      axi_read(A_STATUS, d, r);
      check("status_rx_full", d, 32'h0000_0806);
      axi_write(A_CTRL, 32'h2, 4'hF, r);
      axi_read(A_STATUS, d, r);
      check("status_rx_flushed", d, 32'h0000_000A);

      // Flush racing a DCC push in the same cycle
      for (int i = 0; i < 3; i++) push_rx(32'h11 * 32'(i + 1));
      axi_read(A_STATUS, d, r);
      check("status_rx3", d, 32'h0000_0302);
      @(posedge clk); #1;
      awaddr = A_CTRL; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      rx_valid = 1'b1; rx_data = 32'h44;
      @(negedge clk);
      check("flush_race_aw", awready, 1);
      check("flush_race_rx_ready", rx_ready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; rx_valid = 1'b0;
      axi_read(A_STATUS, d, r);
      check("status_flush_race", d, 32'h0000_000A);
      push_rx(32'h12);
      axi_read(A_RX, d, r);
      check("rx_after_flush", d, 32'h12);

      // Reset while a write response is pending
      axi_write(A_TX, 32'hBEEF, 4'hF, r);
      push_rx(32'h99);
      @(posedge clk); #1;
      bready = 1'b0; awaddr = 6'h14; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      check("pend_aw", awready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check("pend_bvalid", bvalid, 1);
      areset = 1'b1;
      @(negedge clk);
      check("rst_mid_bvalid", bvalid, 0);
      check("rst_mid_tx_valid", tx_valid, 0);
      check("rst_mid_rx_ready", rx_ready, 0);
      @(posedge clk); #1;
      areset = 1'b0; bready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         axi_read(6'h10 + 6'(4 * i), d, r);
         check("scratch_after_rst", d, 0);
      end
      axi_read(A_STATUS, d, r);
      check("status_after_rst", d, 32'h0000_000A);
      axi_read(A_RX, d, r);
      check("rx_empty_after_rst", r, 2'b10);
      @(negedge clk);
      check("tx_valid_after_rst", tx_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
